sum_accumulator: RTL
====================

# sum_accumulator

Streaming accumulator that sits directly downstream of the 32-bit `sample` adder and consumes its sum output `z`. It accepts one addend per valid/ready handshake and adds COUNT consecutive addends into a WIDTH-bit modular sum. It also counts the carry-outs lost to wrap-around. Each completed block is presented on a valid/ready output port and held until the consumer takes it.

## Interface
Parameters:
- WIDTH, 32, data width of the addend and of the sum; matches the adder output.
- COUNT, 4, number of addends per block; legal range 1..1023.
- CW, 8, width of the carry counter.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- clear  input  1  synchronous block abort; discards the partial or held block.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  WIDTH  addend; normally the adder's z.
- out_valid  output  1  out_sum and out_carries hold a completed block.
- out_ready  input  1  consumer accepts the block this cycle.
- out_sum  output  WIDTH  modular sum of the block's COUNT addends.
- out_carries  output  CW  number of carry-outs in the block, saturating at 2^CW-1.

## Operation
- State machine has two states: ACCUM and HOLD.
  - Internal registers: acc[WIDTH-1:0], carries[CW-1:0], cnt[$clog2(COUNT+1)-1:0].
- ACCUM state:
  - in_ready=1 and out_valid=0.
  - An accept happens when in_valid=1 while in_ready=1.
  - On accept, a (WIDTH+1)-bit sum s = acc + in_data is formed.
  - acc <= s[WIDTH-1:0].
  - If s[WIDTH]=1, carries increments, saturating at 2^CW-1.
  - cnt increments.
  - If the accept is the COUNT-th accept, the final acc and carries values are loaded into out_sum and out_carries, and the state goes to HOLD.
- HOLD state:
  - in_ready=0 and out_valid=1.
  - out_sum and out_carries stay stable until the handshake.
  - When out_ready=1, the state returns to ACCUM and acc, carries and cnt are zeroed.
- There is no input bypass in HOLD. Addends presented while in HOLD are not accepted and must be held by the producer.
- clear=1 forces state ACCUM, zeroes acc, carries and cnt, and drives out_valid to 0 from the next cycle.
  - clear overrides any input accept or output handshake in the same cycle.
  - A block being transferred in the same cycle as clear is void, and the consumer must discard it.
- reset has the same effect as clear and additionally zeroes out_sum and out_carries.
- Priority order: reset > clear > handshakes.
- COUNT=1 is legal: every accept completes a block.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_carries=0, internal state ACCUM.
- The first accept can occur in the first cycle after reset is deasserted.
- out_valid rises one cycle after the clock edge that accepts the COUNT-th addend.
- in_ready falls in the same cycle that out_valid rises.
- After an output handshake:
  - out_valid=0 and in_ready=1 in the next cycle.
  - Minimum block period is COUNT+1 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Reset or clear asserted mid-block or in HOLD takes effect at the next edge. No partial data leaks out.
- Wrap-around: sums are modulo 2^WIDTH. Carries are counted, never signalled as an error.

## Test plan
- Reset, then feed 1, 2, 3, 4 with in_valid held high and out_ready=1, COUNT=4:
  - in_ready is 1 for four cycles.
  - Then out_valid=1 with out_sum=0x0000000A and out_carries=0.
  - in_ready=1 the cycle after the handshake.
- Feed 0xFFFFFFFF four times:
  - out_sum=0xFFFFFFFC and out_carries=3.
  - Then feed 0x80000000, 0x80000000, 0, 0: out_sum=0x00000000 and out_carries=1.
- Backpressure: complete a block, then hold out_ready=0 for 5 cycles with in_valid=1 and in_data changing:
  - in_ready stays 0.
  - out_sum and out_carries stay constant.
  - No addend is consumed until one cycle after out_ready rises.
- Clear mid-block: accept 7, 9, pulse clear, then accept 5, 5, 5, 5:
  - out_sum=0x00000014 and out_carries=0.
  - Clear asserted in HOLD drops out_valid at the next edge.
- Reset mid-HOLD with out_ready=0:
  - Next cycle out_valid=0, out_sum=0, out_carries=0, in_ready=1.
  - A fresh block of 1, 1, 1, 1 then yields out_sum=4.
- Saturation with COUNT=300 and CW=8, all addends 0xFFFFFFFF:
  - out_carries=255 (saturated).
  - out_sum=0xFFFFFED4.

Source files
------------

// File: rtl/sum_accumulator.sv
// Streaming block accumulator: sums COUNT addends modulo 2^WIDTH, counts lost
// carry-outs (saturating), and holds each finished block until it is taken.
module sum_accumulator #(
    parameter int WIDTH = 32,
    parameter int COUNT = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CW-1:0]    out_carries
);

    localparam int CNTW = $clog2(COUNT + 1);
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  acc;
    logic [CW-1:0]     carries;
    logic [CNTW-1:0]   cnt;
    logic [WIDTH:0]    sum_ext;
    logic [CW-1:0]     carries_nxt;
    logic              accept;
    logic              last_accept;
    logic              handshake;

    // Outputs decode from state only, so nothing combinational reaches them.
    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        handshake   = 1'b0;
        sum_ext     = {1'b0, acc} + {1'b0, in_data};
        carries_nxt = carries;
        if (sum_ext[WIDTH] && (carries != {CW{1'b1}})) begin
            carries_nxt = carries + CW'(1);
        end
        case (state)
            ACCUM: begin
                in_ready    = 1'b1;
                accept      = in_valid;
                last_accept = in_valid && (cnt == LAST_IDX);
                if (last_accept) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                handshake = out_ready;
                if (out_ready) begin
                    next_state = ACCUM;
                end
            end
            default: begin
                next_state = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Clear voids the running block but leaves the last published result;
    // only reset wipes the output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            carries     <= '0;
            cnt         <= '0;
            out_sum     <= '0;
            out_carries <= '0;
        end else if (clear) begin
            acc     <= '0;
            carries <= '0;
            cnt     <= '0;
        end else if (accept) begin
            acc     <= sum_ext[WIDTH-1:0];
            carries <= carries_nxt;
            cnt     <= cnt + CNTW'(1);
            if (last_accept) begin
                out_sum     <= sum_ext[WIDTH-1:0];
                out_carries <= carries_nxt;
            end
        end else if (handshake) begin
            acc     <= '0;
            carries <= '0;
            cnt     <= '0;
        end
    end

endmodule
